// File: rtl/motor_param_regs.sv
// Register bank between motor_ctrl's bus master channels and a host bridge port.
// Holds velocity target and PID gains, and captures the rotation count pushed by the controller.
module motor_param_regs #(
   parameter logic [7:0]  ADDR_ROTATION_VELOCITY = 8'h00,
   parameter logic [7:0]  ADDR_PROPORTION_GAIN   = 8'h04,
   parameter logic [7:0]  ADDR_INTEGRATION_GAIN  = 8'h08,
   parameter logic [7:0]  ADDR_DERIVATIVE_GAIN   = 8'h0C,
   parameter logic [7:0]  ADDR_ROT_CNT           = 8'h10,
   parameter logic [7:0]  ADDR_WR_SEQ            = 8'h14,
   parameter logic [31:0] RST_ROT_V              = 32'h0,
   parameter logic [31:0] RST_P                  = 32'h0,
   parameter logic [31:0] RST_I                  = 32'h0,
   parameter logic [31:0] RST_D                  = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        w_req,
   input  logic [7:0]  w_addr,
   input  logic [31:0] w_data,
   output logic        w_ack,
   input  logic        r_req,
   input  logic [7:0]  r_addr,
   output logic        r_ack,
   output logic        r_valid,
   output logic [31:0] r_data,
   input  logic        r_rdy,
   input  logic        h_we,
   input  logic        h_re,
   input  logic [7:0]  h_addr,
   input  logic [31:0] h_wdata,
   output logic        h_rvalid,
   output logic [31:0] h_rdata,
   input  logic        h_err_clr,
   output logic        bus_err
);

   typedef enum logic {R_IDLE, R_RESP} rd_state_t;

   rd_state_t   r_state;
   logic [31:0] r_rot_v, r_p, r_i, r_d, r_rot_cnt, r_wr_seq;
   logic [31:0] w_h_rd, w_b_rd;
   logic        w_wr_acc;

   // A write is only taken while no ack is outstanding, giving one write per two cycles.
   assign w_wr_acc = w_req && !w_ack;

   always_comb begin
      w_h_rd = 32'h0;
      case (h_addr)
         ADDR_ROTATION_VELOCITY: w_h_rd = r_rot_v;
         ADDR_PROPORTION_GAIN:   w_h_rd = r_p;
         ADDR_INTEGRATION_GAIN:  w_h_rd = r_i;
         ADDR_DERIVATIVE_GAIN:   w_h_rd = r_d;
         ADDR_ROT_CNT:           w_h_rd = r_rot_cnt;
         ADDR_WR_SEQ:            w_h_rd = r_wr_seq;
         default:                w_h_rd = 32'h0;
      endcase
   end

   always_comb begin
      w_b_rd = 32'h0;
      case (r_addr)
         ADDR_ROTATION_VELOCITY: w_b_rd = r_rot_v;
         ADDR_PROPORTION_GAIN:   w_b_rd = r_p;
         ADDR_INTEGRATION_GAIN:  w_b_rd = r_i;
         ADDR_DERIVATIVE_GAIN:   w_b_rd = r_d;
         ADDR_ROT_CNT:           w_b_rd = r_rot_cnt;
         ADDR_WR_SEQ:            w_b_rd = r_wr_seq;
         default:                w_b_rd = 32'h0;
      endcase
   end

   // Bus write channel, host port and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ack     <= 1'b0;
         bus_err   <= 1'b0;
         h_rvalid  <= 1'b0;
         h_rdata   <= 32'h0;
         r_rot_v   <= RST_ROT_V;
         r_p       <= RST_P;
         r_i       <= RST_I;
         r_d       <= RST_D;
         r_rot_cnt <= 32'h0;
         r_wr_seq  <= 32'h0;
      end else begin
         w_ack <= w_wr_acc;
         if (w_wr_acc && (w_addr == ADDR_ROT_CNT)) begin
            r_rot_cnt <= w_data;
            r_wr_seq  <= r_wr_seq + 32'd1;
         end
         if (w_wr_acc && (w_addr != ADDR_ROT_CNT)) begin
            bus_err <= 1'b1;
         end else if (h_err_clr) begin
            bus_err <= 1'b0;
         end
         if (h_we) begin
            case (h_addr)
               ADDR_ROTATION_VELOCITY: r_rot_v <= h_wdata;
               ADDR_PROPORTION_GAIN:   r_p     <= h_wdata;
               ADDR_INTEGRATION_GAIN:  r_i     <= h_wdata;
               ADDR_DERIVATIVE_GAIN:   r_d     <= h_wdata;
               default: ;
            endcase
         end
         h_rvalid <= h_re;
         if (h_re) begin
            h_rdata <= w_h_rd;
         end
      end
   end

   // Read responder: snapshot on accept, hold until the master consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_ack   <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= 32'h0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (r_req) begin
                  r_data  <= w_b_rd;
                  r_ack   <= 1'b1;
                  r_valid <= 1'b1;
                  r_state <= R_RESP;
               end
            end
            R_RESP: begin
               if (r_rdy) begin
                  r_valid <= 1'b0;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_motor_param_regs.sv
// Bench for motor_param_regs: host/bus read data flows through scoreboard queues,
// host register behaviour is table-driven, bus handshake corners are hand-written sequences.
module tb_motor_param_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        w_req, w_ack, r_req, r_ack, r_valid, r_rdy;
   logic [7:0]  w_addr, r_addr, h_addr;
   logic [31:0] w_data, r_data, h_wdata, h_rdata;
   logic        h_we, h_re, h_rvalid, h_err_clr, bus_err;

   always #5 clk = ~clk;

   motor_param_regs dut (
      .clk(clk), .rst(rst),
      .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
      .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_valid(r_valid),
      .r_data(r_data), .r_rdy(r_rdy),
      .h_we(h_we), .h_re(h_re), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_rvalid(h_rvalid), .h_rdata(h_rdata),
      .h_err_clr(h_err_clr), .bus_err(bus_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] hq[$];
   logic [31:0] rq[$];

   typedef struct {
      logic        we;
      logic        re;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } hvec_t;
   hvec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic host_rd(input logic [7:0] a, input logic [31:0] e);
      h_re = 1'b1;
      h_addr = a;
      hq.push_back(e);
      cyc();
      h_re = 1'b0;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      w_req = 1'b1;
      w_addr = a;
      w_data = d;
      cyc();
      w_req = 1'b0;
      @(negedge clk);
      chk("w_ack_pulse", 32'(w_ack), 32'd1);
      cyc();
   endtask

   // Scoreboard: pop expected read data whenever the DUT presents a response.
   always @(negedge clk) begin
      logic [31:0] e;
      if (h_rvalid) begin
         if (hq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL h_rvalid_unexpected: got data %h with no read pending", h_rdata);
         end else begin
            e = hq.pop_front();
            chk("h_rdata", h_rdata, e);
         end
      end
      if (r_ack) begin
         if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL r_ack_unexpected: got data %h with no request pending", r_data);
         end else begin
            e = rq.pop_front();
            chk("r_data", r_data, e);
            chk("r_valid_with_ack", 32'(r_valid), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; w_req = 1'b0; w_addr = 8'h0; w_data = 32'h0;
      r_req = 1'b0; r_addr = 8'h0; r_rdy = 1'b0;
      h_we = 1'b0; h_re = 1'b0; h_addr = 8'h0; h_wdata = 32'h0; h_err_clr = 1'b0;

      // Host register table: writes, ignored writes, readback, same-cycle write+read.
      tbl.push_back('{1'b1, 1'b0, 8'h04, 32'h0000_1234, 32'h0});
      tbl.push_back('{1'b0, 1'b1, 8'h04, 32'h0,         32'h0000_1234});
      tbl.push_back('{1'b1, 1'b0, 8'h00, 32'hAAAA_5555, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 8'h08, 32'h0000_0011, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 8'h0C, 32'h0000_0022, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 8'h10, 32'h0000_DEAD, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 8'h14, 32'h0000_BEEF, 32'h0});
      tbl.push_back('{1'b1, 1'b0, 8'h30, 32'h0000_CAFE, 32'h0});
      tbl.push_back('{1'b0, 1'b1, 8'h00, 32'h0,         32'hAAAA_5555});
      tbl.push_back('{1'b0, 1'b1, 8'h08, 32'h0,         32'h0000_0011});
      tbl.push_back('{1'b0, 1'b1, 8'h0C, 32'h0,         32'h0000_0022});
      tbl.push_back('{1'b0, 1'b1, 8'h10, 32'h0,         32'h0});
      tbl.push_back('{1'b0, 1'b1, 8'h14, 32'h0,         32'h0});
      tbl.push_back('{1'b0, 1'b1, 8'h30, 32'h0,         32'h0});
      tbl.push_back('{1'b1, 1'b1, 8'h0C, 32'h0000_0033, 32'h0000_0022});
      tbl.push_back('{1'b0, 1'b1, 8'h0C, 32'h0,         32'h0000_0033});

      repeat (3) cyc();
      @(negedge clk);
      chk("rst_w_ack",    32'(w_ack),    32'd0);
      chk("rst_r_ack",    32'(r_ack),    32'd0);
      chk("rst_r_valid",  32'(r_valid),  32'd0);
      chk("rst_r_data",   r_data,        32'd0);
      chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
      chk("rst_h_rdata",  h_rdata,       32'd0);
      chk("rst_bus_err",  32'(bus_err),  32'd0);
      cyc();
      rst = 1'b0;

      host_rd(8'h00, 32'h0); host_rd(8'h04, 32'h0); host_rd(8'h08, 32'h0);
      host_rd(8'h0C, 32'h0); host_rd(8'h10, 32'h0); host_rd(8'h14, 32'h0);
      host_rd(8'h18, 32'h0); host_rd(8'hFF, 32'h0);

      foreach (tbl[k]) begin
         h_we = tbl[k].we; h_re = tbl[k].re;
         h_addr = tbl[k].addr; h_wdata = tbl[k].wdata;
         if (tbl[k].re) hq.push_back(tbl[k].exp);
         cyc();
      end
      h_we = 1'b0; h_re = 1'b0;

      // Bus read of P, response held while r_rdy low; a second request meanwhile is ignored.
      r_req = 1'b1; r_addr = 8'h04; rq.push_back(32'h0000_1234);
      cyc();
      r_addr = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("r_valid_hold", 32'(r_valid), 32'd1);
         chk("r_data_hold",  r_data,       32'h0000_1234);
         cyc();
      end
      r_req = 1'b0; r_rdy = 1'b1;
      cyc();
      r_rdy = 1'b0;
      @(negedge clk);
      chk("r_valid_release", 32'(r_valid), 32'd0);
      cyc();

      // Host write vs bus snapshot of the same register; r_rdy in the first valid cycle.
      h_we = 1'b1; h_addr = 8'h04; h_wdata = 32'h0000_5678;
      r_req = 1'b1; r_addr = 8'h04; rq.push_back(32'h0000_1234);
      cyc();
      h_we = 1'b0; r_req = 1'b0; r_rdy = 1'b1;
      cyc();
      r_rdy = 1'b0;
      @(negedge clk);
      chk("r_valid_fast_drop", 32'(r_valid), 32'd0);
      r_req = 1'b1; r_addr = 8'h04; rq.push_back(32'h0000_5678);
      cyc();
      r_req = 1'b0; r_rdy = 1'b1;
      cyc();
      r_rdy = 1'b0; r_req = 1'b1; r_addr = 8'h99; rq.push_back(32'h0);
      cyc();
      r_req = 1'b0; r_rdy = 1'b1;
      cyc();
      r_rdy = 1'b0;

      // Bus ROT_CNT writes and the write-sequence counter.
      @(negedge clk);
      chk("bus_err_clean", 32'(bus_err), 32'd0);
      cyc();
      bus_wr(8'h10, 32'hFFFF_FF00); bus_wr(8'h10, 32'hFFFF_FF00); bus_wr(8'h10, 32'hFFFF_FF00);
      host_rd(8'h14, 32'd3); host_rd(8'h10, 32'hFFFF_FF00);
      @(negedge clk);
      chk("bus_err_after_rotcnt", 32'(bus_err), 32'd0);

      // w_req held high: only every other cycle is accepted.
      w_req = 1'b1; w_addr = 8'h10; w_data = 32'h55;
      for (int i = 0; i < 4; i++) begin
         cyc();
         @(negedge clk);
         chk("w_ack_held", 32'(w_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      w_req = 1'b0;
      cyc();
      host_rd(8'h14, 32'd5); host_rd(8'h10, 32'h55);

      // Bus ROT_CNT write and host read of it in the same cycle.
      w_req = 1'b1; w_addr = 8'h10; w_data = 32'h77;
      h_re = 1'b1; h_addr = 8'h10; hq.push_back(32'h55);
      cyc();
      w_req = 1'b0; h_re = 1'b0;
      cyc();
      host_rd(8'h14, 32'd6); host_rd(8'h10, 32'h77);

      // Bus write to a host register flags an error and leaves the register alone.
      bus_wr(8'h00, 32'h1234_5678);
      @(negedge clk);
      chk("bus_err_set", 32'(bus_err), 32'd1);
      cyc();
      host_rd(8'h00, 32'hAAAA_5555);
      h_err_clr = 1'b1;
      cyc();
      h_err_clr = 1'b0;
      @(negedge clk);
      chk("bus_err_clr", 32'(bus_err), 32'd0);
      w_req = 1'b1; w_addr = 8'h44; w_data = 32'h1; h_err_clr = 1'b1;
      cyc();
      w_req = 1'b0; h_err_clr = 1'b0;
      @(negedge clk);
      chk("bus_err_set_wins", 32'(bus_err), 32'd1);
      chk("w_ack_unmapped",   32'(w_ack),   32'd1);
      cyc();
      h_err_clr = 1'b1;
      cyc();
      h_err_clr = 1'b0;
      @(negedge clk);
      chk("bus_err_clr2", 32'(bus_err), 32'd0);
      cyc();

      // WR_SEQ wrap from all-ones.
      force dut.r_wr_seq = 32'hFFFF_FFFF;
      #1;
      release dut.r_wr_seq;
      host_rd(8'h14, 32'hFFFF_FFFF);
      bus_wr(8'h10, 32'h1);
      host_rd(8'h14, 32'h0); host_rd(8'h10, 32'h1);

      // Reset while a read response is outstanding.
      r_req = 1'b1; r_addr = 8'h04; rq.push_back(32'h0000_5678);
      cyc();
      r_req = 1'b0;
      @(negedge clk);
      chk("r_valid_before_rst", 32'(r_valid), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("r_valid_after_rst", 32'(r_valid), 32'd0);
      chk("r_data_after_rst",  r_data,       32'd0);
      cyc();
      host_rd(8'h04, 32'h0); host_rd(8'h00, 32'h0); host_rd(8'h14, 32'h0);
      r_req = 1'b1; r_addr = 8'h10; rq.push_back(32'h0);
      cyc();
      r_req = 1'b0; r_rdy = 1'b1;
      cyc();
      r_rdy = 1'b0;

      repeat (3) cyc();
      chk("hq_drained", 32'(hq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
